// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcodes, divider width and divider state encoding
package alu_pkg;
  localparam int DIV_WIDTH = 32;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_MUL = 5'b10000;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;
endpackage

// File: rtl/seq_divider_step.sv
// seq_divider_step: one restoring-division step on unsigned magnitudes
module seq_divider_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] div_i,
  output logic [W:0]   rem_o,
  output logic         q_o
);
  logic [W+1:0] sh;
  logic [W+1:0] diff;
  assign sh    = {rem_i, bit_i};
  assign diff  = sh - {2'b00, div_i};
  assign q_o   = ~diff[W+1];
  assign rem_o = q_o ? diff[W:0] : sh[W:0];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed divider with start/busy/done handshake
import alu_pkg::*;
module seq_divider #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  div_state_e state_q, state_d;
  logic [WIDTH:0] rem_q, rem_d, step_rem;
  logic [WIDTH-1:0] quo_q, quo_d, dmag_q, dmag_d, q_q, q_d, r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d, dbz_q, dbz_d, step_q, accept;
  // quo_q starts as |dividend| and shifts quotient bits in as dividend bits leave
  seq_divider_step #(.W(WIDTH)) u_step (
    .rem_i(rem_q),
    .bit_i(quo_q[WIDTH-1]),
    .div_i(dmag_q),
    .rem_o(step_rem),
    .q_o  (step_q)
  );
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dmag_d  = dmag_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;
    q_d     = q_q;
    r_d     = r_q;
    accept  = start && (state_q == S_IDLE || state_q == S_DONE);
    if (state_q == S_DONE) state_d = S_IDLE;
    if (accept) begin
      quo_d   = dividend[WIDTH-1] ? -dividend : dividend;
      dmag_d  = divisor[WIDTH-1] ? -divisor : divisor;
      qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      rneg_d  = dividend[WIDTH-1];
      cnt_d   = '0;
      rem_d   = '0;
      dbz_d   = (divisor == '0);
      state_d = dbz_d ? S_DONE : S_RUN;
      if (dbz_d) begin
        q_d = '1;
        r_d = dividend;
      end
    end else if (state_q == S_RUN) begin
      rem_d   = step_rem;
      quo_d   = {quo_q[WIDTH-2:0], step_q};
      cnt_d   = cnt_q + CW'(1);
      state_d = (cnt_q == CW'(WIDTH - 1)) ? S_FIX : S_RUN;
    end else if (state_q == S_FIX) begin
      q_d     = qneg_q ? -quo_q : quo_q;
      r_d     = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
      state_d = S_DONE;
    end
  end
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dmag_q  <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dmag_q  <= dmag_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dbz_q   <= dbz_d;
      q_q     <= q_d;
      r_q     <= r_d;
    end
  end
  assign busy        = (state_q == S_RUN) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed-vector bench for seq_divider
module tb_seq_divider;
  logic clock = 1'b0;
  logic clear = 1'b0;
  logic start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic busy, done, div_by_zero;
  logic [31:0] quotient, remainder;
  int n_chk = 0;
  int n_fail = 0;
  seq_divider dut (
    .clock      (clock),
    .clear      (clear),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Called #1 after an edge; a call made while done is high exercises back-to-back start
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                         input int pulse_at);
    int e = 0;
    int bc = 0;
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clock);
    #1;
    start = 1'b0;
    dividend = ~a;
    divisor = b + 32'd1;
    bc = int'(busy);
    while (!done && e < 100) begin
      start = (e == pulse_at);
      if (start) begin
        dividend = 32'd999;
        divisor = 32'd3;
      end
      @(posedge clock);
      #1;
      start = 1'b0;
      e++;
      if (busy) bc++;
    end
    check({tag, " latency"}, 64'(e), edbz ? 64'd0 : 64'd33);
    check({tag, " busy cycles"}, 64'(bc), edbz ? 64'd0 : 64'd33);
    check({tag, " quotient"}, {32'd0, quotient}, {32'd0, eq});
    check({tag, " remainder"}, {32'd0, remainder}, {32'd0, er});
    check({tag, " div_by_zero"}, {63'd0, div_by_zero}, {63'd0, edbz});
  endtask
  initial begin
    #1;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset outputs", {quotient, remainder}, 64'd0);
    check("reset dbz", {63'd0, div_by_zero}, 64'd0);
    #11 clear = 1'b1;
    @(posedge clock);
    #1;
    run_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, -1);
    run_div("-100/7", 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, -1);
    run_div("100/-7", 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0, -1);
    run_div("-100/-7", 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 1'b0, -1);
    run_div("min/-1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, -1);
    run_div("0/5", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, -1);
    run_div("7/100", 32'd7, 32'd100, 32'd0, 32'd7, 1'b0, -1);
    run_div("5/0", 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, -1);
    run_div("-9/0", 32'hFFFFFFF7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF7, 1'b1, -1);
    run_div("12/5", 32'd12, 32'd5, 32'd2, 32'd2, 1'b0, -1);
    repeat (3) @(posedge clock);
    #1;
    check("idle done", {63'd0, done}, 64'd0);
    check("idle busy", {63'd0, busy}, 64'd0);
    check("idle holds result", {quotient, remainder}, {32'd2, 32'd2});
    run_div("100/7 pulse", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 10);
    run_div("77/8", 32'd77, 32'd8, 32'd9, 32'd5, 1'b0, -1);
    start = 1'b1;
    dividend = 32'd100;
    divisor = 32'd7;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #2 clear = 1'b0;
    #1;
    check("clear busy", {63'd0, busy}, 64'd0);
    check("clear done", {63'd0, done}, 64'd0);
    check("clear outputs", {quotient, remainder}, 64'd0);
    check("clear dbz", {63'd0, div_by_zero}, 64'd0);
    #3 clear = 1'b1;
    @(posedge clock);
    #1;
    check("post-clear busy", {63'd0, busy}, 64'd0);
    run_div("1000/10", 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
